// File: rtl/he_ctrl.sv
// Histogram-equalization sequencer: clears the external histogram RAM, accumulates
// one frame of pixels into it, then scans the bins to produce the 256-entry remap LUT.
module he_ctrl #(
  parameter int NUM_PIXELS = 290400,
  parameter int CW         = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_pixel,
  output logic          in_ready,
  output logic [7:0]    hist_addr,
  output logic          hist_we,
  output logic [CW-1:0] hist_wdata,
  input  logic [CW-1:0] hist_rdata,
  output logic          lut_we,
  output logic [7:0]    lut_addr,
  output logic [7:0]    lut_wdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_SCAN, S_DONE
  } state_e;

  localparam logic [CW-1:0] NP_C = CW'(NUM_PIXELS);

  state_e        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_addr_q, pend_addr_d;
  logic          fwd_vld_q, fwd_vld_d;
  logic [7:0]    fwd_addr_q, fwd_addr_d;
  logic [CW-1:0] fwd_data_q, fwd_data_d;
  logic [CW-1:0] cdf_q, cdf_d;

  logic [CW-1:0] upd_data;
  logic [CW-1:0] cdf_new;
  logic [CW+7:0] prod;
  logic [7:0]    lut_val;
  logic          accept;

  // Bin update: reuse the last written value when it targets the same bin.
  always_comb begin
    upd_data = ((fwd_vld_q && (fwd_addr_q == pend_addr_q)) ? fwd_data_q : hist_rdata) + CW'(1);
    cdf_new  = cdf_q + hist_rdata;
    prod     = {8'd0, cdf_new} * (CW+8)'(255);
    lut_val  = 8'(prod / (CW+8)'(NUM_PIXELS));
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      fwd_vld_q   <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      cdf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      fwd_vld_q   <= fwd_vld_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      cdf_q       <= cdf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    fwd_vld_d   = fwd_vld_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    cdf_d       = cdf_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        acc_d     = '0;
        pend_d    = 1'b0;
        fwd_vld_d = 1'b0;
        cdf_d     = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd255) begin
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (pend_q) begin
          pend_d = 1'b0;
        end else if (accept) begin
          pend_d      = 1'b1;
          pend_addr_d = in_pixel;
          acc_d       = acc_q + CW'(1);
          if (acc_q == NP_C - CW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pend_d  = 1'b0;
        cnt_d   = '0;
        cdf_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q != 9'd0) cdf_d = cdf_new;
        if (cnt_q == 9'd256) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (hist_we) begin
      fwd_vld_d  = 1'b1;
      fwd_addr_d = hist_addr;
      fwd_data_d = hist_wdata;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    hist_addr  = '0;
    hist_we    = 1'b0;
    hist_wdata = '0;
    lut_we     = 1'b0;
    lut_addr   = '0;
    lut_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy      = 1'b1;
        hist_we   = 1'b1;
        hist_addr = cnt_q[7:0];
      end
      S_ACCUM: begin
        busy = 1'b1;
        // The single RAM port is taken by the pending write, so accepts alternate.
        if (pend_q) begin
          hist_we    = 1'b1;
          hist_addr  = pend_addr_q;
          hist_wdata = upd_data;
        end else begin
          in_ready  = (acc_q < NP_C);
          hist_addr = in_pixel;
        end
      end
      S_DRAIN: begin
        busy       = 1'b1;
        hist_we    = pend_q;
        hist_addr  = pend_addr_q;
        hist_wdata = upd_data;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (!cnt_q[8]) hist_addr = cnt_q[7:0];
        if (cnt_q != 9'd0) begin
          lut_we    = 1'b1;
          lut_addr  = cnt_q[7:0] - 8'd1;
          lut_wdata = lut_val;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_he_ctrl.sv
// Bench for he_ctrl: three instances (4, 16 and 256 pixels per frame), each with a
// behavioural histogram RAM and LUT memory, driven with directed pixel frames.
module tb_he_ctrl;
  localparam int CW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [2:0]           start, in_valid;
  logic [2:0][7:0]      in_pixel;
  logic [2:0]           in_ready, hist_we, lut_we, busy, done;
  logic [2:0][7:0]      hist_addr, lut_addr, lut_wdata;
  logic [2:0][CW-1:0]   hist_wdata, hist_rdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NP = (g == 0) ? 4 : (g == 1) ? 16 : 256;
    he_ctrl #(.NUM_PIXELS(NP), .CW(CW)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start[g]),
      .in_valid   (in_valid[g]),
      .in_pixel   (in_pixel[g]),
      .in_ready   (in_ready[g]),
      .hist_addr  (hist_addr[g]),
      .hist_we    (hist_we[g]),
      .hist_wdata (hist_wdata[g]),
      .hist_rdata (hist_rdata[g]),
      .lut_we     (lut_we[g]),
      .lut_addr   (lut_addr[g]),
      .lut_wdata  (lut_wdata[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  logic [CW-1:0] hist_mem [3][256];
  logic [7:0]    lut_mem  [3][256];
  int cyc = 0;
  int wr_cnt [3] = '{0, 0, 0};
  int acc_cnt [3] = '{0, 0, 0};
  int last_acc [3] = '{0, 0, 0};
  int done_cyc [3] = '{0, 0, 0};
  int bad_rdy [3] = '{0, 0, 0};

  // Memories and event counters, all updated on the active edge like real flops.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) begin
      if (hist_we[g]) begin
        hist_mem[g][hist_addr[g]] <= hist_wdata[g];
        wr_cnt[g] <= wr_cnt[g] + 1;
      end
      hist_rdata[g] <= hist_mem[g][hist_addr[g]];
      if (lut_we[g]) lut_mem[g][lut_addr[g]] <= lut_wdata[g];
      if (in_valid[g] && in_ready[g]) begin
        acc_cnt[g]  <= acc_cnt[g] + 1;
        last_acc[g] <= cyc;
      end
      if (done[g]) done_cyc[g] <= cyc;
      if (in_ready[g] && (hist_we[g] || !busy[g])) bad_rdy[g] <= bad_rdy[g] + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int pix [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int g, input string tag);
    check_eq({tag, "_ctl"}, 32'({in_ready[g], hist_we[g], lut_we[g], busy[g], done[g]}), 0);
    check_eq({tag, "_addr"}, 32'({hist_addr[g], lut_addr[g], lut_wdata[g]}), 0);
    check_eq({tag, "_wdata"}, 32'(hist_wdata[g]), 0);
  endtask

  task automatic run_frame(input int g, input int np, input bit gaps, input bit poke);
    int idx, guard, wr0, acc0, rdy_after;
    @(negedge clk);
    wr0 = wr_cnt[g];
    acc0 = acc_cnt[g];
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < np && guard < 4000) begin
      in_valid[g] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_pixel[g] = 8'(pix[idx]);
      start[g] = poke && (idx == np / 2);
      #1;
      if (in_valid[g] && in_ready[g]) idx++;
      @(negedge clk);
      guard++;
    end
    check_eq("accept_all", idx, np);
    start[g] = 1'b0;
    in_valid[g] = 1'b1;
    in_pixel[g] = 8'(pix[0]);
    guard = 0;
    rdy_after = 0;
    while (!done[g] && guard < 600) begin
      if (in_ready[g]) rdy_after++;
      start[g] = poke && (guard == 50);
      @(negedge clk);
      guard++;
    end
    start[g] = 1'b0;
    check_eq("done_seen", done[g], 1);
    in_valid[g] = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", done[g], 0);
    check_eq("busy_after", busy[g], 0);
    check_eq("done_lat", done_cyc[g] - last_acc[g], 259);
    check_eq("acc_count", acc_cnt[g] - acc0, np);
    check_eq("hist_writes", wr_cnt[g] - wr0, 256 + np);
    check_eq("rdy_after_last", rdy_after, 0);
    repeat (3) @(negedge clk);
    check_eq("stay_idle", busy[g], 0);
  endtask

  task automatic check_frame(input int g, input int np);
    int e_hist [256];
    int cum;
    for (int k = 0; k < 256; k++) e_hist[k] = 0;
    for (int i = 0; i < np; i++) e_hist[pix[i] & 255]++;
    cum = 0;
    for (int k = 0; k < 256; k++) begin
      cum += e_hist[k];
      check_eq($sformatf("hist%0d[%0d]", g, k), 32'(hist_mem[g][k]), e_hist[k]);
      check_eq($sformatf("lut%0d[%0d]", g, k), 32'(lut_mem[g][k]), (cum * 255) / np);
    end
  endtask

  initial begin
    int guard, got;
    reset = 1'b1;
    start = '0;
    in_valid = '0;
    in_pixel = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check_idle(g, "reset");
    reset = 1'b0;

    // Frame 1: 10,10,10,200 on the 4-pixel instance.
    pix[0] = 10; pix[1] = 10; pix[2] = 10; pix[3] = 200;
    run_frame(0, 4, 1'b0, 1'b0);
    check_frame(0, 4);
    check_eq("t1_hist10", 32'(hist_mem[0][10]), 3);
    check_eq("t1_hist200", 32'(hist_mem[0][200]), 1);
    check_eq("t1_lut9", 32'(lut_mem[0][9]), 0);
    check_eq("t1_lut10", 32'(lut_mem[0][10]), 191);
    check_eq("t1_lut199", 32'(lut_mem[0][199]), 191);
    check_eq("t1_lut200", 32'(lut_mem[0][200]), 255);

    // Frame 2: sixteen zero pixels, every update forwarded.
    for (int i = 0; i < 16; i++) pix[i] = 0;
    run_frame(1, 16, 1'b0, 1'b0);
    check_frame(1, 16);
    check_eq("t2_hist0", 32'(hist_mem[1][0]), 16);
    check_eq("t2_lut0", 32'(lut_mem[1][0]), 255);
    check_eq("t2_lut255", 32'(lut_mem[1][255]), 255);

    // Frame 3, back to back: ten 50s and six 100s; bin 0 must be cleared.
    for (int i = 0; i < 16; i++) pix[i] = (i % 3 == 0) ? 100 : 50;
    run_frame(1, 16, 1'b0, 1'b0);
    check_frame(1, 16);
    check_eq("t3_hist0", 32'(hist_mem[1][0]), 0);
    check_eq("t3_lut49", 32'(lut_mem[1][49]), 0);
    check_eq("t3_lut50", 32'(lut_mem[1][50]), 159);
    check_eq("t3_lut100", 32'(lut_mem[1][100]), 255);

    // Frame 4: ramp 0..255 with valid gaps and stray start pulses.
    for (int i = 0; i < 256; i++) pix[i] = i;
    run_frame(2, 256, 1'b1, 1'b1);
    check_frame(2, 256);
    check_eq("t4_lut0", 32'(lut_mem[2][0]), 0);
    check_eq("t4_lut127", 32'(lut_mem[2][127]), 127);
    check_eq("t4_lut255", 32'(lut_mem[2][255]), 255);

    // Reset in the middle of accumulation, then a clean rerun of frame 1.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_pixel[0] = 8'd10;
    guard = 0;
    got = 0;
    while (got < 2 && guard < 600) begin
      #1;
      if (in_ready[0]) got++;
      @(negedge clk);
      guard++;
    end
    check_eq("mid_accepts", got, 2);
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "mid_reset");
    reset = 1'b0;
    in_valid[0] = 1'b0;
    pix[0] = 10; pix[1] = 10; pix[2] = 10; pix[3] = 200;
    run_frame(0, 4, 1'b0, 1'b0);
    check_frame(0, 4);

    for (int g = 0; g < 3; g++) check_eq($sformatf("bad_ready%0d", g), bad_rdy[g], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
